// File: rtl/fetch_pkg.sv
// Shared types and helpers for the prefetching fetch stage.
// Entry layout, JAL opcode and J-type immediate decode.
package fetch_pkg;

  localparam int FETCH_XLEN = 32;
  localparam int FETCH_ILEN = 32;

  localparam logic [6:0] OPC_JAL = 7'b1101111;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_ILEN-1:0] instr;
    logic                  pred_taken;
  } fetch_entry_t;

  // J-type immediate, bit 0 implicit zero, sign-extended to the PC width
  function automatic logic [FETCH_XLEN-1:0] jal_imm(input logic [FETCH_ILEN-1:0] instr);
    logic [20:0] imm_s;
    imm_s = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    return {{(FETCH_XLEN-21){imm_s[20]}}, imm_s};
  endfunction

endpackage

// File: rtl/fetch_stage_pq_if.sv
// Bundle of redirect, imem request/response and fetch-to-decode handshakes.
// master = fetch stage side, slave = surrounding pipeline/memory side.
interface fetch_stage_pq_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            fd_valid;
  logic            fd_ready;
  logic [XLEN-1:0] fd_pc;
  logic [ILEN-1:0] fd_instr;
  logic            fd_pred_taken;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, fd_ready,
    output imem_req_valid, imem_req_addr, fd_valid, fd_pc, fd_instr, fd_pred_taken
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, fd_ready,
    input  imem_req_valid, imem_req_addr, fd_valid, fd_pc, fd_instr, fd_pred_taken
  );
endinterface

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of fetch entries with flush; head is read straight from storage.
// Pop on an empty queue is ignored; flush wins over push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         empty,
  output logic [CW-1:0] occupancy
);
  fetch_entry_t  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign do_push_s = push && !flush;
  assign do_pop_s  = pop && !flush && (count_r != {CW{1'b0}});

  // Entry storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  assign head      = mem_r[rd_ptr_r];
  assign empty     = (count_r == {CW{1'b0}});
  assign occupancy = count_r;
endmodule

// File: rtl/fetch_queue_chk.sv
// Checker for the prefetch queue: a push into a full queue without a pop
// would mean the request credit accounting is broken.
module fetch_queue_chk #(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input logic          clk,
  input logic          rst,
  input logic          push,
  input logic          pop,
  input logic          flush,
  input logic [CW-1:0] occupancy
);
  property p_no_overflow;
    @(posedge clk) disable iff (rst)
      !(push && !pop && !flush && (occupancy == CW'(DEPTH)));
  endproperty

  a_no_overflow: assert property (p_no_overflow)
    else $error("fetch_queue overflow");
endmodule

// File: rtl/fetch_stage_pq.sv
// Fetch stage with prefetch queue, credit-limited imem requests and drop counting
// of stale responses after a redirect. Optional JAL prediction: FETCH_JAL_PREDICT_EN.
module fetch_stage_pq
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4
) (
  input logic              clk,
  input logic              rst,
  fetch_stage_pq_if.master bus
);
  localparam int              CW           = $clog2(DEPTH) + 1;
  localparam logic [CW:0]     CREDIT_LIMIT = DEPTH[CW:0];
  localparam logic [XLEN-1:0] PC_STEP      = {{(XLEN-3){1'b0}}, 3'd4};

  logic [XLEN-1:0] fetch_pc_r;
  logic [XLEN-1:0] rsp_pc_r;
  logic [CW-1:0]   outstanding_r;
  logic [CW-1:0]   drop_cnt_r;
  logic [CW-1:0]   outstanding_nxt_s;
  logic [CW-1:0]   occ_s;
  logic            empty_s;
  fetch_entry_t    head_s;
  fetch_entry_t    push_entry_s;
  logic            req_valid_s;
  logic            req_fire_s;
  logic            live_rsp_s;
  logic            jal_hit_s;
  logic            push_s;
  logic            pop_s;

  // Responses are live only when nothing stale is still in flight
  assign live_rsp_s = bus.imem_rsp_valid && (drop_cnt_r == {CW{1'b0}}) && !bus.redirect_valid;

`ifdef FETCH_JAL_PREDICT_EN
  logic [XLEN-1:0] jal_tgt_s;
  assign jal_hit_s = live_rsp_s && (bus.imem_rsp_data[6:0] == OPC_JAL);
  assign jal_tgt_s = rsp_pc_r + jal_imm(bus.imem_rsp_data);
`else
  assign jal_hit_s = 1'b0;
`endif

  assign req_valid_s = !rst && !bus.redirect_valid && !jal_hit_s &&
                       (({1'b0, occ_s} + {1'b0, outstanding_r}) < CREDIT_LIMIT);
  assign req_fire_s  = req_valid_s && bus.imem_req_ready;
  assign outstanding_nxt_s = outstanding_r + CW'(req_fire_s) - CW'(bus.imem_rsp_valid);

  assign push_s = live_rsp_s;
  assign pop_s  = !empty_s && bus.fd_ready && !bus.redirect_valid;

  // Queue entry built from the response and its tracked PC
  always_comb begin
    push_entry_s            = '0;
    push_entry_s.pc         = rsp_pc_r;
    push_entry_s.instr      = bus.imem_rsp_data;
    push_entry_s.pred_taken = jal_hit_s;
  end

  // PC tracking, in-flight count and stale-response drop count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r    <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      outstanding_r <= {CW{1'b0}};
      drop_cnt_r    <= {CW{1'b0}};
    end else begin
      outstanding_r <= outstanding_nxt_s;
      if (bus.redirect_valid) begin
        fetch_pc_r <= bus.redirect_pc;
        rsp_pc_r   <= bus.redirect_pc;
        drop_cnt_r <= outstanding_nxt_s;
`ifdef FETCH_JAL_PREDICT_EN
      end else if (jal_hit_s) begin
        fetch_pc_r <= jal_tgt_s;
        rsp_pc_r   <= jal_tgt_s;
        drop_cnt_r <= outstanding_nxt_s;
`endif
      end else begin
        if (req_fire_s) begin
          fetch_pc_r <= fetch_pc_r + PC_STEP;
        end
        if (bus.imem_rsp_valid) begin
          if (drop_cnt_r != {CW{1'b0}}) begin
            drop_cnt_r <= drop_cnt_r - CW'(1'b1);
          end else begin
            rsp_pc_r <= rsp_pc_r + PC_STEP;
          end
        end
      end
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .flush      (bus.redirect_valid),
    .head       (head_s),
    .empty      (empty_s),
    .occupancy  (occ_s)
  );

  fetch_queue_chk #(.DEPTH(DEPTH)) u_queue_chk (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .pop       (pop_s),
    .flush     (bus.redirect_valid),
    .occupancy (occ_s)
  );

  // Only JAL hits ever store pred_taken=1, so this is constant 0 without prediction
  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_req_addr  = fetch_pc_r;
  assign bus.fd_valid       = !empty_s;
  assign bus.fd_pc          = empty_s ? {XLEN{1'b0}} : head_s.pc;
  assign bus.fd_instr       = empty_s ? {ILEN{1'b0}} : head_s.instr;
  assign bus.fd_pred_taken  = empty_s ? 1'b0 : head_s.pred_taken;
endmodule

// File: tb/tb_fetch_stage_pq.sv
// Self-checking bench for fetch_stage_pq: directed tables, redirect/reset sequences
// and randomized traffic against a queue-based model of in-flight requests.
module tb_fetch_stage_pq;
  import fetch_pkg::*;

  localparam int          XLEN     = 32;
  localparam int          ILEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_stage_pq_if #(.XLEN(XLEN), .ILEN(ILEN)) bus ();

  fetch_stage_pq #(.XLEN(XLEN), .ILEN(ILEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { logic [31:0] addr; int due; bit stale; } inflight_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } fd_t;
  typedef struct { bit fdr; bit rv; logic [31:0] addr; bit fv; logic [31:0] pc; } vec_t;

  inflight_t   pend[$];
  fd_t         expq[$];
  logic [31:0] m_pc;
  bit          m_rv;
  int          cyc = 0;
  int          lat = 1;
  bit          stall_rsp = 1'b0;
  int          tests = 0;
  int          fails = 0;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[8:2], 2'b00, 7'b0010011};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Apply one cycle's inputs at the current (negedge) time and settle
  task automatic drive(input bit rdr, input logic [31:0] rpc, input bit fdr, input bit rqr);
    bus.redirect_valid = rdr;
    bus.redirect_pc    = rpc;
    bus.fd_ready       = fdr;
    bus.imem_req_ready = rqr;
    if (pend.size() > 0 && pend[0].due <= cyc && (!stall_rsp || $urandom_range(0, 3) != 0)) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = memw(pend[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    m_rv = !rdr && ((expq.size() + pend.size()) < DEPTH);
    #1;
  endtask

  task automatic model_check();
    check("req_valid", 32'(bus.imem_req_valid), 32'(m_rv));
    check("req_addr", bus.imem_req_addr, m_pc);
    check("fd_valid", 32'(bus.fd_valid), 32'(expq.size() > 0));
    if (expq.size() > 0) begin
      check("fd_pc", bus.fd_pc, expq[0].pc);
      check("fd_instr", bus.fd_instr, expq[0].instr);
    end
    check("fd_pred", 32'(bus.fd_pred_taken), 32'h0);
  endtask

  // Advance the model across the coming clock edge, then wait for the next negedge
  task automatic model_step();
    bit        live;
    fd_t       e;
    inflight_t n;
    live = 1'b0;
    if (bus.imem_rsp_valid) begin
      live    = !pend[0].stale && !bus.redirect_valid;
      e.pc    = pend[0].addr;
      e.instr = memw(pend[0].addr);
      void'(pend.pop_front());
    end
    if (bus.redirect_valid) begin
      expq.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      m_pc = bus.redirect_pc;
    end else begin
      if (bus.fd_ready && expq.size() > 0) void'(expq.pop_front());
      if (live) expq.push_back(e);
      if (m_rv && bus.imem_req_ready) begin
        n.addr  = m_pc;
        n.due   = cyc + lat;
        n.stale = 1'b0;
        pend.push_back(n);
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic mcycle(input bit rdr, input logic [31:0] rpc, input bit fdr, input bit rqr);
    drive(rdr, rpc, fdr, rqr);
    model_check();
    model_step();
  endtask

  task automatic clear_inputs();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.fd_ready       = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    pend.delete();
    expq.delete();
    m_pc = RESET_PC;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    check("rst_fd_valid", 32'(bus.fd_valid), 32'h0);
    check("rst_fd_pc", bus.fd_pc, 32'h0);
    check("rst_fd_instr", bus.fd_instr, 32'h0);
    check("rst_fd_pred", 32'(bus.fd_pred_taken), 32'h0);
    rst = 1'b0;
  endtask

  task automatic check_vec(input string name, input vec_t v);
    check({name, "_req_valid"}, 32'(bus.imem_req_valid), 32'(v.rv));
    check({name, "_req_addr"}, bus.imem_req_addr, v.addr);
    check({name, "_fd_valid"}, 32'(bus.fd_valid), 32'(v.fv));
    if (v.fv) begin
      check({name, "_fd_pc"}, bus.fd_pc, v.pc);
      check({name, "_fd_instr"}, bus.fd_instr, memw(v.pc));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t1[5];
    vec_t t2[12];
    bit   seen;
    int   k_seen;

    t1 = '{'{1'b1, 1'b1, 32'h00, 1'b0, 32'h0},
           '{1'b1, 1'b1, 32'h04, 1'b0, 32'h0},
           '{1'b1, 1'b1, 32'h08, 1'b1, 32'h0},
           '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h4},
           '{1'b1, 1'b1, 32'h10, 1'b1, 32'h8}};
    t2 = '{'{1'b0, 1'b1, 32'h00, 1'b0, 32'h00},
           '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00},
           '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00},
           '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h00},
           '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00},
           '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00},
           '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00},
           '{1'b1, 1'b0, 32'h10, 1'b1, 32'h00},
           '{1'b1, 1'b1, 32'h10, 1'b1, 32'h04},
           '{1'b1, 1'b1, 32'h14, 1'b1, 32'h08},
           '{1'b1, 1'b1, 32'h18, 1'b1, 32'h0C},
           '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10}};

    // Streaming with 1-cycle imem and decode always ready
    lat = 1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h0, t1[i].fdr, 1'b1);
      check_vec("stream", t1[i]);
      model_step();
    end

    // Decode stalled: credit limit then drain without loss
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 32'h0, t2[i].fdr, 1'b1);
      check_vec("stall", t2[i]);
      model_step();
    end

    // Redirect with 3 requests in flight on a 3-cycle imem
    lat = 3;
    do_reset();
    repeat (3) mcycle(1'b0, 32'h0, 1'b1, 1'b1);
    mcycle(1'b1, 32'h100, 1'b1, 1'b1);
    seen   = 1'b0;
    k_seen = -1;
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1);
      model_check();
      if (!seen && bus.fd_valid) begin
        seen   = 1'b1;
        k_seen = k;
        check("redir_fd_pc", bus.fd_pc, 32'h100);
        check("redir_fd_instr", bus.fd_instr, memw(32'h100));
      end
      model_step();
    end
    check("redir_seen", 32'(seen), 32'h1);
    check("redir_latency", k_seen, 32'd4);

    // Redirect in the same cycle as a response and a dequeue
    lat = 2;
    do_reset();
    repeat (4) mcycle(1'b0, 32'h0, 1'b1, 1'b1);
    drive(1'b1, 32'h200, 1'b1, 1'b1);
    check("coinc_rsp_present", 32'(bus.imem_rsp_valid), 32'h1);
    check("coinc_fd_valid_before", 32'(bus.fd_valid), 32'h1);
    check("coinc_no_req", 32'(bus.imem_req_valid), 32'h0);
    model_check();
    model_step();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1);
      check("coinc_fd_valid_after", 32'(bus.fd_valid), 32'h0);
      model_check();
      model_step();
    end
    repeat (6) mcycle(1'b0, 32'h0, 1'b1, 1'b1);

    // Randomized traffic: stalls on both sides, varying latency, random redirects
    stall_rsp = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0) lat = $urandom_range(1, 4);
      mcycle(($urandom_range(0, 15) == 0), 32'($urandom_range(0, 255)) * 32'd4,
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    end
    stall_rsp = 1'b0;

    // Asynchronous reset mid-stream clears outputs without a clock edge
    lat = 1;
    repeat (6) mcycle(1'b0, 32'h0, 1'b1, 1'b1);
    check("pre_rst_fd_valid", 32'(bus.fd_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    check("arst_fd_valid", 32'(bus.fd_valid), 32'h0);
    check("arst_fd_pc", bus.fd_pc, 32'h0);
    check("arst_fd_instr", bus.fd_instr, 32'h0);
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    check("resume_req_valid", 32'(bus.imem_req_valid), 32'h1);
    check("resume_req_addr", bus.imem_req_addr, RESET_PC);
    model_check();
    model_step();
    repeat (8) mcycle(1'b0, 32'h0, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_stage_pq.md
Name: fetch_stage_pq

Overview:
- Parametrised next-generation fetch stage. Decouples PC generation from decode through a DEPTH-entry prefetch queue and a valid/ready handshake.
- Talks to instruction memory over a request/response interface that allows several requests in flight, with in-order responses of any latency.
- Takes redirects (branch resolution) from execute and discards stale in-flight responses by drop counting.
- Sits between imem and the decode pipeline register.

Parameters:
- XLEN, 32, PC/address width
- ILEN, 32, instruction width
- RESET_PC, 32'h0000_0000, PC after reset
- DEPTH, 4, prefetch queue entries; power of two, >=2; also the limit on requests in flight

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- redirect_valid  in  1  execute redirect request
- redirect_pc  in  XLEN  redirect target
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  XLEN  fetch address
- imem_req_ready  in  1  imem accepts request
- imem_rsp_valid  in  1  response valid (in order)
- imem_rsp_data  in  ILEN  fetched instruction
- fd_valid  out  1  queue head valid to decode
- fd_ready  in  1  decode accepts head
- fd_pc  out  XLEN  PC of head instruction
- fd_instr  out  ILEN  head instruction
- fd_pred_taken  out  1  head was predicted taken (0 when the feature is off)

Behaviour:
- Reset (async, rst=1): queue empty; fetch_pc=RESET_PC; rsp_pc=RESET_PC; outstanding=0; drop_cnt=0; imem_req_valid=0; fd_valid=0; fd_pc=0; fd_instr=0; fd_pred_taken=0.
- Credit rule:
  - imem_req_valid = !rst && !redirect_valid && !jal_hit && (occupancy + outstanding < DEPTH).
  - imem_req_addr = fetch_pc.
  - req_fire = valid && ready.
- On req_fire: fetch_pc += 4; outstanding += 1.
- Response handling:
  - On imem_rsp_valid: outstanding -= 1.
  - If drop_cnt > 0: discard and decrement drop_cnt.
  - Otherwise enqueue {rsp_pc, data, pred} and set rsp_pc += 4.
  - The queue can never overflow because of the credit rule; an overflow is an assertion failure.
- Dequeue on fd_valid && fd_ready. fd_* come from the registered queue head; fd_valid = !empty.
- Enqueue and dequeue in the same cycle leave occupancy unchanged.
- Full queue with fd_ready=0: requests stop and the head holds stable.
- Pointers wrap mod DEPTH; occupancy width is clog2(DEPTH)+1.
- Redirect (redirect_valid=1):
  - Next cycle: queue empty, fetch_pc=rsp_pc=redirect_pc.
  - drop_cnt = outstanding - imem_rsp_valid; outstanding is left unchanged apart from that response.
  - A response arriving in the redirect cycle is discarded.
  - No request is issued in the redirect cycle.
  - fd_valid=0 the cycle after a redirect; the first new fd_valid appears no earlier than 2 cycles plus imem latency after the redirect.
- Redirect has priority over dequeue and JAL prediction in the same cycle.
- Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Reset mid-operation drops all in-flight state. Responses still arriving after rst deasserts (imem is reset together with fetch) are undefined and out of scope.

Optional Feature:
- Macro FETCH_JAL_PREDICT_EN.
- When defined, a live (non-dropped) response with opcode 7'b1101111 (JAL):
  - is enqueued with pred=1;
  - the next cycle sets fetch_pc = rsp_pc + sext(J-imm) and rsp_pc = that same target;
  - sets drop_cnt = outstanding - imem_rsp_valid (stale sequential fetches);
  - gates the request in that cycle (jal_hit);
  - keeps the queue contents.
- When undefined: jal_hit=0, fd_pred_taken tied to 0, no JAL decode logic.

Decomposition:
- Package fetch_pkg:
  - fetch_entry_t {pc, instr, pred_taken};
  - OPC_JAL constant;
  - function jal_imm(instr) returning XLEN sign-extended immediate.
- Sub-module fetch_queue: parametrised DEPTH FIFO of fetch_entry_t, with push/pop/flush/occupancy ports.

Test Plan:
- Reset then imem_req_ready=1, 1-cycle rsp latency, fd_ready=1 -> addrs 0x0,0x4,0x8 issued; fd_pc 0x0,0x4,0x8 on consecutive cycles; fd_valid first high 2 cycles after reset release.
- fd_ready=0, DEPTH=4 -> exactly 4 requests issued, then imem_req_valid=0; head stays 0x0; on release, fd_pc sequence 0x0..0xC with no loss.
- imem latency 3, 3 requests in flight, redirect_pc=0x100 -> 3 responses discarded; next fd_pc=0x100 with imem_rsp_data of the 0x100 request.
- Redirect coinciding with imem_rsp_valid and fd_ready -> that response dropped; drop_cnt=outstanding-1; no spurious fd_valid.
- FETCH_JAL_PREDICT_EN, instr at 0x8 = JAL +0x40 -> fd_pred_taken=1 for 0x8; next fd_pc=0x48; 0xC/0x10 never presented.
- Async rst asserted mid-stream -> outputs cleared immediately without a clock edge; fetch resumes at RESET_PC.
